// File: rtl/if_axi_fetch_pkg.sv
// rtl/if_axi_fetch_pkg.sv - shared encodings and constants for the instruction-fetch stage
package if_axi_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_ADDR = 2'd1,
      FETCH_DATA = 2'd2,
      FETCH_HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INST      = 32'h0000_0000;
   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
   // instruction access, secure, unprivileged
   localparam logic [2:0]  ARPROT_INST   = 3'b100;

endpackage

// File: rtl/if_axi_fetch.sv
// rtl/if_axi_fetch.sv - PC to AXI4-Lite read fetch stage with registered IF/ID output
module if_axi_fetch
   import if_axi_fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(if_axi_fetch_pkg::NOP_INST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              fetch_en_i,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic              stallreq_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_valid_o,
   output logic              fetch_err_o,
   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
);

   fetch_state_t      state, state_n;
   logic              discard, discard_n;
   logic [ADDR_W-1:0] araddr_n;

   // one-entry buffer for a beat that arrived while decode was stalled
   logic [DATA_W-1:0] hold_data;
   logic [ADDR_W-1:0] hold_pc;
   logic              hold_err;
   logic              hold_ld;

   logic              deliver;
   logic [DATA_W-1:0] del_data;
   logic [ADDR_W-1:0] del_pc;
   logic              del_err;
   logic              r_err;

   assign r_err   = (rresp != AXI_RESP_OKAY);
   assign arprot  = ARPROT_INST;
   assign arvalid = (state == FETCH_ADDR);
   assign rready  = (state == FETCH_DATA);

   // PC may move only when an instruction leaves, fetching is off, or a flush reloads it
   assign stallreq_o = !(deliver || !fetch_en_i || flush_i);

   // next-state, discard tracking and delivery selection
   always_comb begin
      state_n   = state;
      discard_n = discard;
      araddr_n  = araddr;
      hold_ld   = 1'b0;
      deliver   = 1'b0;
      del_data  = rdata;
      del_pc    = araddr;
      del_err   = r_err;
      case (state)
         FETCH_IDLE: begin
            if (fetch_en_i && !flush_i) begin
               araddr_n = pc_i;
               state_n  = FETCH_ADDR;
            end
         end
         FETCH_ADDR: begin
            // arvalid must stay up until accepted, so a flush only marks the beat stale
            if (flush_i)
               discard_n = 1'b1;
            if (arready)
               state_n = FETCH_DATA;
         end
         FETCH_DATA: begin
            if (rvalid) begin
               state_n   = FETCH_IDLE;
               discard_n = 1'b0;
               if (!discard && !flush_i) begin
                  if (stall_i) begin
                     hold_ld = 1'b1;
                     state_n = FETCH_HOLD;
                  end else begin
                     deliver = 1'b1;
                  end
               end
            end else if (flush_i) begin
               discard_n = 1'b1;
            end
         end
         FETCH_HOLD: begin
            del_data = hold_data;
            del_pc   = hold_pc;
            del_err  = hold_err;
            if (flush_i) begin
               state_n = FETCH_IDLE;
            end else if (!stall_i) begin
               deliver = 1'b1;
               state_n = FETCH_IDLE;
            end
         end
         default: state_n = FETCH_IDLE;
      endcase
   end

   // control state and the AR address register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= FETCH_IDLE;
         discard <= 1'b0;
         araddr  <= '0;
      end else begin
         state   <= state_n;
         discard <= discard_n;
         araddr  <= araddr_n;
      end
   end

   // capture a returned beat that decode could not take yet
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_data <= '0;
         hold_pc   <= '0;
         hold_err  <= 1'b0;
      end else if (hold_ld) begin
         hold_data <= rdata;
         hold_pc   <= araddr;
         hold_err  <= r_err;
      end
   end

   // IF/ID output registers: flush clears, deliver loads, stall holds, otherwise a bubble
   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_o       <= NOP_INST;
         inst_pc_o    <= '0;
         inst_valid_o <= 1'b0;
         fetch_err_o  <= 1'b0;
      end else if (flush_i) begin
         inst_o       <= NOP_INST;
         inst_valid_o <= 1'b0;
         fetch_err_o  <= 1'b0;
      end else if (deliver) begin
         inst_o       <= del_err ? NOP_INST : del_data;
         inst_pc_o    <= del_pc;
         inst_valid_o <= 1'b1;
         fetch_err_o  <= del_err;
      end else if (!stall_i) begin
         inst_o       <= NOP_INST;
         inst_valid_o <= 1'b0;
         fetch_err_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_axi_fetch.sv
// tb/tb_if_axi_fetch.sv - self-checking bench for if_axi_fetch with a behavioural AXI slave and PC model
module tb_if_axi_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        fetch_en_i, flush_i, stall_i;
   logic        stallreq_o;
   logic [31:0] inst_o, inst_pc_o;
   logic        inst_valid_o, fetch_err_o;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;

   always #5 clk = ~clk;

   if_axi_fetch dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .fetch_en_i(fetch_en_i), .flush_i(flush_i),
      .stall_i(stall_i), .stallreq_o(stallreq_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
      .inst_valid_o(inst_valid_o), .fetch_err_o(fetch_err_o), .araddr(araddr), .arprot(arprot),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
      .rready(rready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // instruction memory contents seen by the slave
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hbfc00000) return 32'h3c080001;
      if (a == 32'hbfc00008) return 32'h24020005;
      return (a * 32'h9e3779b1) ^ 32'h13572468;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      if (a == 32'hbfc00384) return 1'b1;
      if (a[31:28] == 4'hb) return 1'b0;
      return (a[4:2] == 3'd5);
   endfunction

   // stimulus knobs
   logic        rst_v = 1'b0, fen = 1'b0, stall_v = 1'b0, flush_v = 1'b0;
   logic [31:0] newpc = 32'h0;
   int          ar_lat = -1, r_lat = -1;

   // architectural PC model: next instruction expected at the output
   logic [31:0] pc_m = 32'hbfc00000;

   // what happened in the previous cycle
   logic        p_rst_low = 1'b0, p_flush = 1'b0, p_stall = 1'b0, p_deliver = 1'b0;
   logic        p_arvalid = 1'b0, p_ar_hs = 1'b0, p_r_hs = 1'b0;
   logic [31:0] p_araddr = 32'h0, p_newpc = 32'h0;

   // outputs observed after the previous edge
   logic        o_valid = 1'b0, o_err = 1'b0;
   logic [31:0] o_inst = 32'h0, o_pc = 32'h0;

   // slave state
   int          ar_cnt = 0, ar_need = 0, r_cnt = 0, r_need = 0;
   logic        busy = 1'b0;
   logic [31:0] s_addr = 32'h0;

   int          cyc = 0, n_ar_hs = 0, n_deliv = 0, idle_run = 0;

   task automatic drive_half();
      rst        = rst_v;
      fetch_en_i = fen;
      stall_i    = stall_v;
      flush_i    = flush_v;
      pc_i       = pc_m;
      if (busy) check("ar_while_busy", 32'(arvalid), 32'd0);
      if (arvalid && !busy) begin
         if (ar_cnt == 0) ar_need = (ar_lat >= 0) ? ar_lat : $urandom_range(0, 3);
         arready = (ar_cnt >= ar_need);
      end else begin
         arready = 1'($urandom_range(0, 1));
      end
      rvalid = busy && (r_cnt >= r_need);
      rdata  = rvalid ? mem_word(s_addr) : $urandom;
      rresp  = rvalid ? (mem_err(s_addr) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
      #1;
      if (arvalid) check("arprot", 32'(arprot), 32'd4);
      if (rvalid)  check("rready_with_rvalid", 32'(rready), 32'd1);
      p_rst_low = !rst_v;
      p_flush   = flush_v && rst_v;
      p_stall   = stall_v;
      p_deliver = rst_v && fen && !flush_v && !stallreq_o;
      p_arvalid = arvalid;
      p_araddr  = araddr;
      p_ar_hs   = arvalid && arready;
      p_r_hs    = rvalid && rready;
      p_newpc   = newpc;
   endtask

   task automatic edge_half();
      @(posedge clk);
      #1;
      cyc++;
      if (p_rst_low) begin
         busy   = 1'b0;
         ar_cnt = 0;
      end else begin
         if (p_r_hs) busy = 1'b0;
         else if (busy && !rvalid) r_cnt++;
         if (p_ar_hs) begin
            busy   = 1'b1;
            s_addr = p_araddr;
            r_cnt  = 0;
            r_need = (r_lat >= 0) ? r_lat : $urandom_range(0, 3);
            ar_cnt = 0;
            n_ar_hs++;
         end else if (p_arvalid) begin
            ar_cnt++;
         end
      end
      if (p_arvalid && !p_ar_hs && !p_rst_low) begin
         check("ar_hold_valid", 32'(arvalid), 32'd1);
         check("ar_hold_addr", araddr, p_araddr);
      end
      if (p_rst_low) begin
         check("rst_valid", 32'(inst_valid_o), 32'd0);
         check("rst_inst", inst_o, NOP);
         check("rst_pc", inst_pc_o, 32'd0);
         check("rst_err", 32'(fetch_err_o), 32'd0);
         check("rst_arvalid", 32'(arvalid), 32'd0);
         check("rst_rready", 32'(rready), 32'd0);
      end else if (p_flush) begin
         check("flush_valid", 32'(inst_valid_o), 32'd0);
         check("flush_inst", inst_o, NOP);
         check("flush_err", 32'(fetch_err_o), 32'd0);
      end else if (p_deliver) begin
         check("dlv_valid", 32'(inst_valid_o), 32'd1);
         check("dlv_pc", inst_pc_o, pc_m);
         check("dlv_err", 32'(fetch_err_o), 32'(mem_err(pc_m)));
         check("dlv_inst", inst_o, mem_err(pc_m) ? NOP : mem_word(pc_m));
         n_deliv++;
      end else if (!p_stall) begin
         check("bubble_valid", 32'(inst_valid_o), 32'd0);
         check("bubble_inst", inst_o, NOP);
      end else begin
         check("stall_hold_valid", 32'(inst_valid_o), 32'(o_valid));
         check("stall_hold_inst", inst_o, o_inst);
         check("stall_hold_pc", inst_pc_o, o_pc);
         check("stall_hold_err", 32'(fetch_err_o), 32'(o_err));
      end
      if (p_deliver || p_flush || p_rst_low || !fen) idle_run = 0;
      else idle_run++;
      if (idle_run > 60) begin
         check("stuck_cycles", 32'(idle_run), 32'd60);
         idle_run = 0;
      end
      if (p_rst_low)      pc_m = 32'hbfc00000;
      else if (p_flush)   pc_m = p_newpc;
      else if (p_deliver) pc_m = pc_m + 32'd4;
      o_valid = inst_valid_o;
      o_inst  = inst_o;
      o_pc    = inst_pc_o;
      o_err   = fetch_err_o;
   endtask

   task automatic run_cycle();
      drive_half();
      edge_half();
   endtask

   // one fetch from IDLE: latency to inst_valid_o and number of PC-advance cycles
   task automatic fetch_test(input string tag, input int st_from, input int st_to, input int exp_lat);
      int  start;
      int  n_low;
      bit  got;
      start = cyc;
      n_low = 0;
      got   = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         stall_v = (i >= st_from && i <= st_to);
         drive_half();
         if (!stallreq_o) n_low++;
         edge_half();
         if (inst_valid_o) got = 1'b1;
      end
      stall_v = 1'b0;
      check({tag, "_latency"}, 32'(cyc - start), 32'(exp_lat));
      check({tag, "_stallreq_low_cycles"}, 32'(n_low), 32'd1);
   endtask

   initial begin
      int hs0;
      int start;
      rst = 1'b0; fetch_en_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; pc_i = 32'h0;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

      rst_v = 1'b0;
      run_cycle();
      run_cycle();
      rst_v = 1'b1;

      // fetch disabled: no request, PC free
      fen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_half();
         check("fen0_stallreq", 32'(stallreq_o), 32'd0);
         check("fen0_arvalid", 32'(arvalid), 32'd0);
         edge_half();
      end

      // best case
      fen = 1'b1; ar_lat = 0; r_lat = 0;
      fetch_test("t1", -1, -1, 3);
      check("t1_inst", inst_o, 32'h3c080001);
      check("t1_pc", inst_pc_o, 32'hbfc00000);

      // slow arready
      ar_lat = 4;
      hs0 = n_ar_hs;
      fetch_test("t2", -1, -1, 7);
      check("t2_ar_handshakes", 32'(n_ar_hs - hs0), 32'd1);

      // decode stalled for three cycles when the beat arrives
      ar_lat = 0;
      fetch_test("t3", 2, 4, 6);
      check("t3_inst", inst_o, 32'h24020005);
      check("t3_pc", inst_pc_o, 32'hbfc00008);

      // flush while the AR is still pending
      ar_lat = 3;
      hs0 = n_ar_hs;
      start = cyc;
      run_cycle();
      flush_v = 1'b1; newpc = 32'hbfc00380;
      run_cycle();
      flush_v = 1'b0; ar_lat = 0;
      for (int i = 0; i < 40 && !inst_valid_o; i++) run_cycle();
      check("t4_latency", 32'(cyc - start), 32'd9);
      check("t4_pc", inst_pc_o, 32'hbfc00380);
      check("t4_ar_handshakes", 32'(n_ar_hs - hs0), 32'd2);

      // bus error response
      fetch_test("t5", -1, -1, 3);
      check("t5_valid", 32'(inst_valid_o), 32'd1);
      check("t5_err", 32'(fetch_err_o), 32'd1);
      check("t5_inst", inst_o, 32'h0);

      // reset while waiting for the R beat
      r_lat = 3;
      run_cycle();
      run_cycle();
      rst_v = 1'b0;
      run_cycle();
      rst_v = 1'b1;
      check("t6_arvalid", 32'(arvalid), 32'd0);
      check("t6_rready", 32'(rready), 32'd0);
      check("t6_valid", 32'(inst_valid_o), 32'd0);
      r_lat = 0;
      fetch_test("t7", -1, -1, 3);
      check("t7_inst", inst_o, 32'h3c080001);

      // randomized traffic
      ar_lat = -1; r_lat = -1;
      hs0 = n_deliv;
      for (int n = 0; n < 3000; n++) begin
         stall_v = ($urandom_range(0, 3) == 0);
         flush_v = ($urandom_range(0, 29) == 0);
         newpc   = $urandom & 32'h7fff_fffc;
         rst_v   = ($urandom_range(0, 499) != 0);
         run_cycle();
      end
      stall_v = 1'b0; flush_v = 1'b0; rst_v = 1'b1;
      for (int n = 0; n < 20; n++) run_cycle();
      check("random_enough_deliveries", 32'((n_deliv - hs0) > 150), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
